// File: rtl/demux_pkg.sv
// Shared constants and mode encoding for the 1-to-4 TDM demultiplexer.
package demux_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;
  localparam int OVR_W = 8;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

endpackage

// File: rtl/demux_chan_slot.sv
// One-entry output holding slot with valid/ready handshake.
// Latency: load appears on y_dat/y_valid one edge later; slot_rdy is high when empty or draining.
module demux_chan_slot #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             y_ready,
  output logic [WIDTH-1:0] y_dat,
  output logic             y_valid,
  output logic             slot_rdy
);

  assign slot_rdy = !y_valid || y_ready;

  // Data is left untouched on a plain drain; only the valid flag drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_dat   <= '0;
      y_valid <= 1'b0;
    end else if (load) begin
      y_dat   <= din;
      y_valid <= 1'b1;
    end else if (y_valid && y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_tdm_1x4.sv
// Registered 1-to-4 TDM demux: explicit or round-robin target, one-cycle accept-to-valid latency.
// Stalls (din_ready=0) while the target slot is full and not draining; DEMUX_OVERRUN_CNT_EN adds a stall counter.
module demux_tdm_1x4
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     S,
  output logic [NCH*WIDTH-1:0] Y,
  output logic [NCH-1:0]       y_valid,
  input  logic [NCH-1:0]       y_ready,
  output logic [SEL_W-1:0]     cur_ch,
  output logic [OVR_W-1:0]     overrun_cnt
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] tgt;
  logic [NCH-1:0]   slot_rdy;
  logic [NCH-1:0]   load;
  logic             accept;
  logic             rr_mode;

  assign rr_mode   = (mode_e'(mode) == MODE_RR);
  assign tgt       = rr_mode ? ptr : S;
  assign cur_ch    = tgt;
  assign din_ready = slot_rdy[tgt];
  assign accept    = din_valid && din_ready;

  // Strict ordering: the pointer never skips a blocked channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept && rr_mode) begin
      ptr <= ptr + 1'b1;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    assign load[c] = accept && (tgt == SEL_W'(c));

    demux_chan_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[c]),
      .din      (din),
      .y_ready  (y_ready[c]),
      .y_dat    (Y[c*WIDTH +: WIDTH]),
      .y_valid  (y_valid[c]),
      .slot_rdy (slot_rdy[c])
    );
  end

`ifdef DEMUX_OVERRUN_CNT_EN
  logic [OVR_W-1:0] ovr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q <= '0;
    end else if (din_valid && !din_ready && (ovr_q != {OVR_W{1'b1}})) begin
      ovr_q <= ovr_q + 1'b1;
    end
  end

  assign overrun_cnt = ovr_q;
`else
  assign overrun_cnt = '0;
`endif

endmodule
